// File: rtl/nor_bist_if.sv
// Purpose: bus between the BIST controller and the NOR gate under test.
//   dut_a, dut_b : stimulus driven by the controller (master)
//   dut_o        : NOR response returned by the gate under test (slave)
interface nor_bist_if;
  logic dut_a;
  logic dut_b;
  logic dut_o;

  modport master (output dut_a, output dut_b, input dut_o);
  modport slave  (input dut_a, input dut_b, output dut_o);
endinterface

// File: rtl/nor_bist_ctrl.sv
// Purpose: built-in self-test sequencer for a 2-input NOR gate.
//   Applies an exhaustive (4 vectors) or LFSR pseudo-random (N_RANDOM vectors)
//   sequence. Each vector is held SETTLE_CYCLES cycles and then checked against
//   a golden NOR. The block reports pass/fail, the error count and the first
//   failing vector.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode         run request (sampled in IDLE only); 0=exhaustive, 1=random
//   nor_if (master)     dut_a/dut_b stimulus out, dut_o response in
//   busy, done          run in progress; one-cycle end-of-run pulse
//   pass                last completed run had no mismatches
//   err_count           saturating mismatch count for the current/last run
//   fail_a, fail_b      inputs of the first mismatching vector
module nor_bist_ctrl #(
  parameter int unsigned N_RANDOM      = 10,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  nor_bist_if.master        nor_if,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic              fail_a,
  output logic              fail_b
);

  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);
  localparam logic [7:0]    LAST_RND = 8'(N_RANDOM - 1);
  localparam logic [7:0]    LAST_EXH = 8'd3;
  localparam logic [15:0]   LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          mode_q, mode_d;
  logic          a_q, a_d, b_q, b_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]    err_q, err_d;
  logic          fa_q, fa_d, fb_q, fb_d;
  logic          ff_q, ff_d;
  logic          mismatch_c;
  logic          last_c;

  // One right-shift step of the Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

  // Case inequality so an X/Z response counts as a mismatch.
  assign mismatch_c = (nor_if.dut_o !== (~a_q & ~b_q));
  assign last_c     = mode_q ? (idx_q == LAST_RND) : (idx_q == LAST_EXH);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      mode_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fa_q    <= 1'b0;
      fb_q    <= 1'b0;
      ff_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      ff_q    <= ff_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    ff_d    = ff_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          err_d   = '0;
          fa_d    = 1'b0;
          fb_d    = 1'b0;
          ff_d    = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          // First random vector uses the seed after one shift.
          lfsr_d  = lfsr_step(LFSR_SEED);
          a_d     = mode ? lfsr_d[0] : 1'b0;
          b_d     = mode ? lfsr_d[1] : 1'b0;
          busy_d  = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CW'(1);
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          if (!ff_q) begin
            ff_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        if (!last_c) begin
          idx_d   = idx_q + 8'd1;
          lfsr_d  = lfsr_step(lfsr_q);
          a_d     = mode_q ? lfsr_d[0] : idx_d[1];
          b_d     = mode_q ? lfsr_d[1] : idx_d[0];
          cnt_d   = CNT_INIT;
          state_d = SETTLE;
        end else begin
          // Final check is folded into pass on the same edge DONE is entered.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == 8'd0);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign nor_if.dut_a = a_q;
  assign nor_if.dut_b = b_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_a       = fa_q;
  assign fail_b       = fb_q;

endmodule

// File: tb/tb_nor_bist_ctrl.sv
// Bench for nor_bist_ctrl: a NOR gate model with selectable faults sits on the
// bus; each run is checked cycle by cycle against a vector list and result
// computed directly from the vector-order and scoring rules.
module tb_nor_bist_ctrl;

  localparam int unsigned NR  = 10;
  localparam int unsigned SC  = 1;
  localparam int unsigned P   = SC + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       busy, done, pass, fail_a, fail_b;
  logic [7:0] err_count;
  int         fault = 0;   // 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 drives X

  int n_assert = 0;
  int n_fail   = 0;

  nor_bist_if nif ();

  nor_bist_ctrl #(.N_RANDOM(NR), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .nor_if    (nif),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b)
  );

  always #5 clk = ~clk;

  function automatic logic gate_out(input int f, input logic a, input logic b);
    case (f)
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return 1'bx;
      default: return !(a || b);
    endcase
  endfunction

  assign nif.dut_o = gate_out(fault, nif.dut_a, nif.dut_b);

  // Vector i of a run, returned as {a,b}.
  function automatic logic [1:0] vec_of(input logic m, input int i);
    logic [15:0] l;
    if (!m) return 2'(i);
    l = SEED;
    for (int k = 0; k <= i; k++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return {l[0], l[1]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"},    16'(nif.dut_a), 16'd0);
    chk({tag, "_b"},    16'(nif.dut_b), 16'd0);
    chk({tag, "_busy"}, 16'(busy),      16'd0);
    chk({tag, "_done"}, 16'(done),      16'd0);
    chk({tag, "_pass"}, 16'(pass),      16'd0);
    chk({tag, "_err"},  16'(err_count), 16'd0);
    chk({tag, "_fa"},   16'(fail_a),    16'd0);
    chk({tag, "_fb"},   16'(fail_b),    16'd0);
  endtask

  // One complete run. hold keeps start high for a back-to-back run;
  // glitch (1..edges-1, 0 = none) pulses start with the other mode mid-run.
  task automatic run(input logic m, input int f, input bit hold, input int glitch);
    int          nv;
    int          errs;
    logic [1:0]  first;
    bit          seen;
    logic [1:0]  v [$];
    nv = m ? NR : 4;
    errs = 0; first = 2'b00; seen = 0;
    for (int i = 0; i < nv; i++) begin
      v.push_back(vec_of(m, i));
      if (gate_out(f, v[i][1], v[i][0]) !== !(v[i][1] || v[i][0])) begin
        errs++;
        if (!seen) begin seen = 1; first = v[i]; end
      end
    end
    if (errs > 255) errs = 255;
    fault = f;
    if (!start) @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin start = 1'b0; mode = $urandom_range(0, 1); end
    chk("accept_busy", 16'(busy), 16'd1);
    chk("accept_done", 16'(done), 16'd0);
    chk("accept_vec",  16'({nif.dut_a, nif.dut_b}), 16'(v[0]));
    chk("accept_err",  16'(err_count), 16'd0);
    chk("accept_pass", 16'(pass), 16'd0);
    for (int k = 1; k <= nv * P; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == glitch) begin start = 1'b1; mode = ~m; end
      else if (!hold) start = 1'b0;
      if (k < nv * P) begin
        chk("run_done", 16'(done), 16'd0);
        chk("run_busy", 16'(busy), 16'd1);
        chk("run_vec",  16'({nif.dut_a, nif.dut_b}), 16'(v[k / P]));
      end else begin
        chk("end_done", 16'(done), 16'd1);
        chk("end_busy", 16'(busy), 16'd0);
        chk("end_pass", 16'(pass), 16'(errs == 0));
        chk("end_err",  16'(err_count), 16'(errs));
        chk("end_fail", 16'({fail_a, fail_b}), 16'(first));
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (hold) mode = m;
    chk("post_done", 16'(done), 16'd0);
    chk("post_busy", 16'(busy), 16'd0);
    chk("post_pass", 16'(pass), 16'(errs == 0));
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed: good, stuck-at-0, stuck-at-1, X response, random twice.
    run(1'b0, 0, 1'b0, 0);
    run(1'b0, 1, 1'b0, 0);
    run(1'b0, 2, 1'b0, 0);
    run(1'b0, 3, 1'b0, 0);
    run(1'b1, 0, 1'b0, 0);
    run(1'b1, 0, 1'b0, 0);

    // Reset asserted at edge 3 of a run.
    fault = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("after_reset_done", 16'(done), 16'd0);
    end
    run(1'b0, 0, 1'b0, 0);

    // Start pulsed while busy, then back-to-back runs with start held.
    run(1'b0, 0, 1'b0, 3);
    run(1'b1, 2, 1'b0, 7);
    run(1'b0, 0, 1'b1, 0);
    run(1'b1, 2, 1'b1, 0);
    run(1'b0, 1, 1'b0, 0);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      logic m;
      int   f;
      int   g;
      m = 1'($urandom_range(0, 1));
      f = $urandom_range(0, 3);
      g = $urandom_range(0, 1) ? $urandom_range(1, (m ? NR : 4) * P - 1) : 0;
      run(m, f, 1'b0, g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
